// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared integer-core constants and the writeback request type
package core_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NREGS      = 32;
   localparam int CNTW       = 2;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_req_t;

endpackage

// File: rtl/writeback_unit_if.sv
// rtl/writeback_unit_if.sv - result sources, issue query, operand lookup and write port bundle
interface writeback_unit_if;
   import core_pkg::*;

   logic                  issue_valid;
   logic [REG_ADDR_W-1:0] issue_rd;
   logic                  issue_ready;

   logic                  alu_valid;
   logic [REG_ADDR_W-1:0] alu_rd;
   logic [XLEN-1:0]       alu_data;
   logic                  alu_ready;

   logic                  mem_valid;
   logic [REG_ADDR_W-1:0] mem_rd;
   logic [XLEN-1:0]       mem_data;
   logic                  mem_ready;

   logic [REG_ADDR_W-1:0] rs1;
   logic [REG_ADDR_W-1:0] rs2;
   logic                  rs1_busy;
   logic                  rs2_busy;
   logic                  rs1_fwd_valid;
   logic                  rs2_fwd_valid;
   logic [XLEN-1:0]       rs1_fwd_data;
   logic [XLEN-1:0]       rs2_fwd_data;

   logic                  wb_we;
   logic [REG_ADDR_W-1:0] wb_rd;
   logic [XLEN-1:0]       wb_data;

   modport slave (
      input  issue_valid, issue_rd,
      output issue_ready,
      input  alu_valid, alu_rd, alu_data,
      output alu_ready,
      input  mem_valid, mem_rd, mem_data,
      output mem_ready,
      input  rs1, rs2,
      output rs1_busy, rs2_busy, rs1_fwd_valid, rs2_fwd_valid, rs1_fwd_data, rs2_fwd_data,
      output wb_we, wb_rd, wb_data
   );

   modport master (
      output issue_valid, issue_rd,
      input  issue_ready,
      output alu_valid, alu_rd, alu_data,
      input  alu_ready,
      output mem_valid, mem_rd, mem_data,
      input  mem_ready,
      output rs1, rs2,
      input  rs1_busy, rs2_busy, rs1_fwd_valid, rs2_fwd_valid, rs1_fwd_data, rs2_fwd_data,
      input  wb_we, wb_rd, wb_data
   );

endinterface

// File: rtl/writeback_unit_scoreboard.sv
// rtl/writeback_unit_scoreboard.sv - per-register pending-write counters and busy lookups
module wb_scoreboard #(
   parameter int NREGS = core_pkg::NREGS,
   parameter int CNTW  = core_pkg::CNTW
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            issue_valid,
   input  logic [core_pkg::REG_ADDR_W-1:0] issue_rd,
   output logic                            issue_ready,
   input  logic                            dec_valid,
   input  logic [core_pkg::REG_ADDR_W-1:0] dec_rd,
   input  logic [core_pkg::REG_ADDR_W-1:0] rs1,
   input  logic [core_pkg::REG_ADDR_W-1:0] rs2,
   output logic                            rs1_busy,
   output logic                            rs2_busy
);
   import core_pkg::*;

   localparam logic [CNTW-1:0] CNT_MAX = '1;

   logic [CNTW-1:0] cnt [NREGS];
   logic            issue_fire;

   // A saturated counter blocks further issue to that register; x0 never blocks
   always_comb begin
      issue_ready = (issue_rd == '0) || (cnt[issue_rd] != CNT_MAX);
      issue_fire  = issue_valid && issue_ready && (issue_rd != '0);
   end

   // Increment on accepted issue, decrement on grant; both together cancel, and x0 stays zero
   always_ff @(posedge clk) begin
      cnt[0] <= '0;
      for (int r = 1; r < NREGS; r++) begin
         if (rst) begin
            cnt[r] <= '0;
         end else begin
            if (issue_fire && (issue_rd == REG_ADDR_W'(r)) &&
                !(dec_valid && (dec_rd == REG_ADDR_W'(r)))) begin
               cnt[r] <= cnt[r] + CNTW'(1);
            end else if (dec_valid && (dec_rd == REG_ADDR_W'(r)) &&
                         !(issue_fire && (issue_rd == REG_ADDR_W'(r))) &&
                         (cnt[r] != '0)) begin
               cnt[r] <= cnt[r] - CNTW'(1);
            end
         end
      end
   end

   // Operand busy reflects any write not yet taken into the stage register
   always_comb begin
      rs1_busy = (cnt[rs1] != '0);
      rs2_busy = (cnt[rs2] != '0);
   end

endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - arbitrates ALU/load results onto the register file write port
module writeback_unit #(
   parameter int XLEN  = core_pkg::XLEN,
   parameter int NREGS = core_pkg::NREGS,
   parameter int CNTW  = core_pkg::CNTW
) (
   input  logic              clk,
   input  logic              rst,
   writeback_unit_if.slave   bus
);
   import core_pkg::*;

   wb_req_t               grant;
   logic                  grant_valid;
   logic                  stage_we;
   logic [REG_ADDR_W-1:0] stage_rd;
   logic [XLEN-1:0]       stage_data;

   // Loads win the port outright; the ALU only goes when no load is offered
   always_comb begin
      bus.mem_ready = 1'b1;
      bus.alu_ready = !bus.mem_valid;
      grant_valid   = bus.mem_valid || bus.alu_valid;
      if (bus.mem_valid) begin
         grant.rd   = bus.mem_rd;
         grant.data = bus.mem_data;
      end else begin
         grant.rd   = bus.alu_rd;
         grant.data = bus.alu_data;
      end
   end

   // Stage register feeding the register file; address/data hold while idle
   always_ff @(posedge clk) begin
      if (rst) begin
         stage_we   <= 1'b0;
         stage_rd   <= '0;
         stage_data <= '0;
      end else if (grant_valid) begin
         stage_we   <= (grant.rd != '0);
         stage_rd   <= grant.rd;
         stage_data <= grant.data;
      end else begin
         stage_we   <= 1'b0;
      end
   end

   // Bypass the value sitting on the write port before the register file shows it
   always_comb begin
      bus.wb_we         = stage_we;
      bus.wb_rd         = stage_rd;
      bus.wb_data       = stage_data;
      bus.rs1_fwd_valid = stage_we && (stage_rd == bus.rs1) && (bus.rs1 != '0);
      bus.rs2_fwd_valid = stage_we && (stage_rd == bus.rs2) && (bus.rs2 != '0);
      bus.rs1_fwd_data  = stage_data;
      bus.rs2_fwd_data  = stage_data;
   end

   wb_scoreboard #(
      .NREGS (NREGS),
      .CNTW  (CNTW)
   ) u_scoreboard (
      .clk         (clk),
      .rst         (rst),
      .issue_valid (bus.issue_valid),
      .issue_rd    (bus.issue_rd),
      .issue_ready (bus.issue_ready),
      .dec_valid   (grant_valid),
      .dec_rd      (grant.rd),
      .rs1         (bus.rs1),
      .rs2         (bus.rs2),
      .rs1_busy    (bus.rs1_busy),
      .rs2_busy    (bus.rs2_busy)
   );

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - directed self-checking bench for writeback_unit
module tb_writeback_unit;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   int   m_cnt [32];

   writeback_unit_if bus ();

   writeback_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Tracks outstanding writes from driven inputs so retiring an unissued rd is caught
   task automatic tick();
      logic       g_v;
      logic [4:0] g_rd;
      logic       inc;
      logic       dec;
      if (rst) begin
         for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      end else begin
         g_v  = bus.mem_valid || bus.alu_valid;
         g_rd = bus.mem_valid ? bus.mem_rd : bus.alu_rd;
         inc  = bus.issue_valid && (bus.issue_rd != 0) && (m_cnt[bus.issue_rd] != 3);
         dec  = g_v && (g_rd != 0);
         if (dec) begin
            total++;
            assert (m_cnt[g_rd] != 0) else begin
               bad++;
               $error("FAIL dec_at_zero rd=%0d observed=0 expected=nonzero", g_rd);
            end
         end
         if (inc && !dec) m_cnt[bus.issue_rd]++;
         else if (dec && !inc && m_cnt[g_rd] != 0) m_cnt[g_rd]--;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst             = 1'b1;
      bus.issue_valid = 1'b0;
      bus.issue_rd    = 5'd0;
      bus.alu_valid   = 1'b0;
      bus.alu_rd      = 5'd0;
      bus.alu_data    = 32'h0;
      bus.mem_valid   = 1'b0;
      bus.mem_rd      = 5'd0;
      bus.mem_data    = 32'h0;
      bus.rs1         = 5'd1;
      bus.rs2         = 5'd2;
      tick();
      tick();
      rst = 1'b0;
      tick();

      // reset / idle
      bus.issue_rd = 5'd5;
      #1;
      chk("rst_wb_we", 32'(bus.wb_we), 32'd0);
      chk("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
      chk("rst_wb_data", bus.wb_data, 32'h0);
      chk("rst_rs1_busy", 32'(bus.rs1_busy), 32'd0);
      chk("rst_rs2_busy", 32'(bus.rs2_busy), 32'd0);
      chk("rst_issue_ready", 32'(bus.issue_ready), 32'd1);

      // issue x5, result three cycles later
      bus.issue_valid = 1'b1;
      bus.rs1         = 5'd5;
      tick();
      bus.issue_valid = 1'b0;
      #1;
      chk("x5_busy_c1", 32'(bus.rs1_busy), 32'd1);
      tick();
      chk("x5_busy_c2", 32'(bus.rs1_busy), 32'd1);
      tick();
      bus.alu_valid = 1'b1;
      bus.alu_rd    = 5'd5;
      bus.alu_data  = 32'hDEADBEEF;
      #1;
      chk("x5_busy_c3", 32'(bus.rs1_busy), 32'd1);
      chk("x5_alu_ready", 32'(bus.alu_ready), 32'd1);
      tick();
      bus.alu_valid = 1'b0;
      #1;
      chk("x5_wb_we", 32'(bus.wb_we), 32'd1);
      chk("x5_wb_rd", 32'(bus.wb_rd), 32'd5);
      chk("x5_wb_data", bus.wb_data, 32'hDEADBEEF);
      chk("x5_fwd_valid", 32'(bus.rs1_fwd_valid), 32'd1);
      chk("x5_fwd_data", bus.rs1_fwd_data, 32'hDEADBEEF);
      chk("x5_busy_c4", 32'(bus.rs1_busy), 32'd0);
      tick();
      chk("x5_wb_we_off", 32'(bus.wb_we), 32'd0);
      chk("x5_wb_rd_hold", 32'(bus.wb_rd), 32'd5);
      chk("x5_fwd_off", 32'(bus.rs1_fwd_valid), 32'd0);

      // mem and alu collide: mem first, alu the cycle after
      bus.issue_valid = 1'b1;
      bus.issue_rd    = 5'd3;
      tick();
      bus.issue_rd    = 5'd4;
      tick();
      bus.issue_valid = 1'b0;
      bus.rs1         = 5'd3;
      bus.rs2         = 5'd4;
      bus.mem_valid   = 1'b1;
      bus.mem_rd      = 5'd3;
      bus.mem_data    = 32'h11;
      bus.alu_valid   = 1'b1;
      bus.alu_rd      = 5'd4;
      bus.alu_data    = 32'h22;
      #1;
      chk("arb_mem_ready", 32'(bus.mem_ready), 32'd1);
      chk("arb_alu_ready", 32'(bus.alu_ready), 32'd0);
      chk("arb_x3_busy", 32'(bus.rs1_busy), 32'd1);
      chk("arb_x4_busy", 32'(bus.rs2_busy), 32'd1);
      tick();
      bus.mem_valid = 1'b0;
      #1;
      chk("arb_x3_we", 32'(bus.wb_we), 32'd1);
      chk("arb_x3_rd", 32'(bus.wb_rd), 32'd3);
      chk("arb_x3_data", bus.wb_data, 32'h11);
      chk("arb_x3_fwd", 32'(bus.rs1_fwd_valid), 32'd1);
      chk("arb_x3_busy_clr", 32'(bus.rs1_busy), 32'd0);
      chk("arb_x4_still_busy", 32'(bus.rs2_busy), 32'd1);
      chk("arb_alu_ready2", 32'(bus.alu_ready), 32'd1);
      tick();
      bus.alu_valid = 1'b0;
      #1;
      chk("arb_x4_rd", 32'(bus.wb_rd), 32'd4);
      chk("arb_x4_data", bus.wb_data, 32'h22);
      chk("arb_x4_fwd", 32'(bus.rs2_fwd_valid), 32'd1);
      chk("arb_x3_fwd_off", 32'(bus.rs1_fwd_valid), 32'd0);
      chk("arb_x4_busy_clr", 32'(bus.rs2_busy), 32'd0);

      // saturate x7
      bus.issue_valid = 1'b1;
      bus.issue_rd    = 5'd7;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("sat_ready_fill", 32'(bus.issue_ready), 32'd1);
         tick();
      end
      chk("sat_ready_x7", 32'(bus.issue_ready), 32'd0);
      bus.issue_rd = 5'd8;
      #1;
      chk("sat_ready_x8", 32'(bus.issue_ready), 32'd1);
      bus.issue_valid = 1'b0;
      bus.issue_rd    = 5'd7;
      bus.mem_valid   = 1'b1;
      bus.mem_rd      = 5'd7;
      bus.mem_data    = 32'h77;
      #1;
      chk("sat_ready_x7_hold", 32'(bus.issue_ready), 32'd0);
      tick();
      bus.mem_valid = 1'b0;
      #1;
      chk("sat_ready_x7_back", 32'(bus.issue_ready), 32'd1);

      // issue and retire x9 together keeps it busy; rd=0 result writes nothing
      bus.issue_valid = 1'b1;
      bus.issue_rd    = 5'd9;
      bus.rs1         = 5'd9;
      bus.rs2         = 5'd0;
      tick();
      bus.alu_valid = 1'b1;
      bus.alu_rd    = 5'd9;
      bus.alu_data  = 32'h99;
      tick();
      bus.issue_valid = 1'b0;
      bus.alu_rd      = 5'd0;
      bus.alu_data    = 32'hFFFF;
      #1;
      chk("x9_busy_kept", 32'(bus.rs1_busy), 32'd1);
      chk("x9_wb_rd", 32'(bus.wb_rd), 32'd9);
      chk("x9_fwd_busy_both", 32'(bus.rs1_fwd_valid), 32'd1);
      chk("x0_alu_ready", 32'(bus.alu_ready), 32'd1);
      chk("x0_never_busy", 32'(bus.rs2_busy), 32'd0);
      tick();
      bus.alu_valid = 1'b0;
      #1;
      chk("x0_wb_we", 32'(bus.wb_we), 32'd0);
      chk("x0_wb_rd", 32'(bus.wb_rd), 32'd0);
      chk("x0_wb_data", bus.wb_data, 32'hFFFF);
      chk("x0_x9_busy", 32'(bus.rs1_busy), 32'd1);
      chk("x0_fwd_x0", 32'(bus.rs2_fwd_valid), 32'd0);

      // reset while x2 pending and x9 still busy
      bus.issue_valid = 1'b1;
      bus.issue_rd    = 5'd2;
      bus.rs2         = 5'd2;
      tick();
      bus.issue_valid = 1'b0;
      bus.mem_valid   = 1'b1;
      bus.mem_rd      = 5'd0;
      bus.mem_data    = 32'h5;
      #1;
      chk("rst2_x2_busy_before", 32'(bus.rs2_busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.mem_valid = 1'b0;
      #1;
      chk("rst2_x2_busy", 32'(bus.rs2_busy), 32'd0);
      chk("rst2_x9_busy", 32'(bus.rs1_busy), 32'd0);
      chk("rst2_wb_we", 32'(bus.wb_we), 32'd0);
      chk("rst2_wb_rd", 32'(bus.wb_rd), 32'd0);
      chk("rst2_wb_data", bus.wb_data, 32'h0);
      chk("rst2_issue_ready", 32'(bus.issue_ready), 32'd1);
      tick();
      chk("rst2_wb_we_idle", 32'(bus.wb_we), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
Writer side of the integer register file. Accepts completed results from two execution sources (ALU and load/store unit) over valid/ready handshakes. Arbitrates them onto the register file's single write port through a registered stage. Keeps a per-register pending-write scoreboard and supplies bypass data for the cycle before the register file reflects a write, so issue logic can stall or forward.

Parameters:
XLEN, 32, data width of results and write port
NREGS, 32, number of architectural registers (x0 hardwired zero)
CNTW, 2, width of per-register pending counter (max outstanding writes per rd = 2^CNTW-1)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
issue_valid  in  1  issue stage dispatches an instruction that will write issue_rd
issue_rd  in  5  destination of dispatched instruction
issue_ready  out  1  low when issue_rd counter is saturated
alu_valid  in  1  ALU result available
alu_rd  in  5  ALU destination
alu_data  in  XLEN  ALU result
alu_ready  out  1  ALU result accepted this cycle
mem_valid  in  1  load result available
mem_rd  in  5  load destination
mem_data  in  XLEN  load result
mem_ready  out  1  load result accepted this cycle
rs1, rs2  in  5 each  source registers being read by decode
rs1_busy, rs2_busy  out  1 each  write pending, not yet committed to the stage register
rs1_fwd_valid, rs2_fwd_valid  out  1 each  bypass hit on the write-port stage
rs1_fwd_data, rs2_fwd_data  out  XLEN each  bypass data
wb_we  out  1  register file write enable
wb_rd  out  5  register file write address
wb_data  out  XLEN  register file write data

Behaviour:
- Reset: wb_we=0, wb_rd=0, wb_data=0, all pending counters=0. Reset mid-operation discards the stage register and all pending state; ready outputs follow the combinational rules.
- Arbitration (combinational):
  - mem has fixed priority: mem_ready=1 always.
  - alu_ready = !mem_valid.
  - Grant = (mem_valid) ? mem : (alu_valid ? alu : none).
- Commit stage, at posedge N+1 after a grant in cycle N:
  - wb_rd <= granted rd; wb_data <= granted data.
  - wb_we <= (granted rd != 0).
  - With no grant, wb_we <= 0 and wb_rd/wb_data hold.
  - Latency: result handshake to wb_we high is 1 cycle. The register file write lands at the end of that cycle.
- Pending counters cnt[r], r = 1..NREGS-1; cnt[0] is constant 0:
  - inc = issue_valid && issue_ready && issue_rd != 0 && issue_rd == r.
  - dec = grant && granted rd == r && r != 0.
  - inc only: +1. dec only: -1. Both in the same cycle: unchanged.
  - dec with cnt==0 is a protocol error: the counter holds at 0, and the bench flags it with an assertion.
- issue_ready = (issue_rd == 0) || (cnt[issue_rd] != max).
- rsX_busy = cnt[rsX] != 0, combinational. x0 is never busy.
- rsX_fwd_valid = wb_we && wb_rd == rsX && rsX != 0. rsX_fwd_data = wb_data.
- A register can be both busy (a later write is pending) and fwd_valid (an older write is on the port). Issue logic treats busy as stall priority.
- rd==0 results are accepted and consume a grant slot. They produce no write and no counter change.
- Both sources valid every cycle: ALU is starved until mem_valid drops. Fairness is the producer's responsibility.

Decomposition:
- Shared package (core_pkg): XLEN, REG_ADDR_W=5, NREGS, typedef wb_req_t {rd, data}.
- One sub-module, wb_scoreboard: counter array, inc/dec, issue_ready, busy lookups.
- The top level holds the arbiter, stage register and forwarding compare.

Test Plan:
- Reset, then idle -> wb_we=0, wb_rd=0, wb_data=0; rs1_busy=rs2_busy=0; issue_ready=1.
- Issue rd=5 at cycle 0; alu_valid rd=5 data=0xDEADBEEF at cycle 3 -> rs1(=5)_busy=1 during cycles 1–3; cycle 4: wb_we=1, wb_rd=5, wb_data=0xDEADBEEF, rs1_fwd_valid=1, rs1_busy=0.
- mem_valid rd=3 data=0x11 and alu_valid rd=4 data=0x22 in the same cycle -> mem_ready=1, alu_ready=0; next cycle writes x3=0x11; ALU held, granted one cycle later, writes x4=0x22.
- Issue rd=7 three times with no results -> issue_ready=0 on the fourth attempt with rd=7, issue_ready=1 for rd=8; one result for x7 -> issue_ready for rd=7 returns to 1 the next cycle.
- Issue rd=9 and retire rd=9 in the same cycle with cnt=1 -> cnt stays 1, rs busy remains 1; alu result with rd=0 data=0xFFFF -> alu_ready=1, wb_we stays 0, no busy change.
- Issue rd=2, assert rst for one cycle before its result -> cnt cleared, rs(=2)_busy=0, wb_we=0 after reset.
